lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the byte-addressed data memory. Sits between the MEM pipeline stage and the memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Drives the memory's MemRead/MemWrite/addr/wd, always word-aligned. Performs sub-word stores by read-modify-write.
- Returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses.

Parameters:
MEM_BYTES, 1024, memory size in bytes; any access whose last byte is at an address >= MEM_BYTES is an error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse (load data or store ack)
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned, out-of-range or illegal size
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
addr  out  32  memory byte address, bits [1:0] always 0
wd  out  32  memory write data
rd  in  32  memory read data (combinational, little-endian: byte at addr is rd[7:0])

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. MemRead=0, MemWrite=0, addr=0, wd=0. Captured request registers cleared.
- A request is accepted at a posedge with req_valid=1 and req_ready=1; all req_* fields are registered at that edge.
- req_ready=1 only in IDLE.
- States: IDLE, LD, ST, RMW_RD, RMW_WR.
- Accept transitions:
  - error → IDLE, with resp_valid=1 and resp_err=1 in the following cycle.
  - load → LD.
  - word store → ST.
  - byte/half store → RMW_RD.
- LD: MemRead=1, addr=word address. At the edge, rd is shifted by addr[1:0] bytes and extended into resp_rdata. Next cycle is IDLE with resp_valid=1. Load latency: accept edge + 2 cycles to resp_valid.
- ST: MemWrite=1, wd=req_wdata. Next cycle is IDLE with resp_valid=1 (ack).
- RMW_RD: MemRead=1. Registers rd at the edge.
- RMW_WR: MemWrite=1. wd = captured word with the target byte or halfword lanes replaced by req_wdata[7:0] or req_wdata[15:0]. Next cycle is IDLE with resp_valid=1.
- MemRead and MemWrite are each high only in their own states and never high together.
- Error conditions:
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - size=11
  - addr+bytes > MEM_BYTES
  - Errors cause no memory access.
- resp_valid is a single-cycle pulse in the IDLE cycle that follows completion. req_ready=1 in that same cycle, so back-to-back requests issue with no bubble.
- Reset mid-operation: returns to IDLE immediately and MemWrite drops asynchronously, so no partial or merged write can occur. The pending response is discarded.

Optional Feature:
LSU_ONECYC_RMW_EN:
- Defined: byte/half stores use a single state RMW. MemRead=1 and MemWrite=1 in the same cycle, and wd is merged combinationally from rd. Sub-word store ack arrives at accept + 2 cycles, and RMW_RD/RMW_WR are removed.
- Undefined: the two-cycle RMW described above; ack at accept + 3, and MemRead and MemWrite are never simultaneous.

Test Plan:
1. Preload bytes 0x10..0x13 = F5,66,77,88.
   - LB 0x10 → resp_rdata=0xFFFFFFF5 two cycles after accept.
   - LBU 0x10 → 0x000000F5.
2. LH 0x12 → 0xFFFF8877. LHU 0x12 → 0x00008877. LW 0x10 → 0x887766F5, with addr=0x10 seen on the memory port.
3. SB wdata=0x123456AB to 0x11:
   - MemWrite high exactly one cycle with wd=0x8877ABF5; ack at accept+3 (accept+2 with LSU_ONECYC_RMW_EN).
   - Then LW 0x10 → 0x8877ABF5.
4. Error cases, each giving resp_valid=1, resp_err=1, resp_rdata=0, with MemRead/MemWrite never asserted:
   - LW 0x12
   - SH 0x13
   - LW 0x3FC (legal control case: no error)
   - LW 0x400
   - size=11
5. Reset during RMW_RD of SH 0xBEEF at 0x10 → MemWrite never rises. Word 0x10 is unchanged. req_ready=1 and resp_valid=0 after release.
6. req_valid held high with LW 0x10, SW 0xDEADBEEF at 0x14, LW 0x14 → second request accepted in the first's resp_valid cycle; final resp_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-organised, byte-addressed data memory.
// Build option: define LSU_ONECYC_RMW_EN to merge sub-word stores in a single read+write cycle.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

`ifdef LSU_ONECYC_RMW_EN
  typedef enum logic [2:0] {IDLE = 3'd0, LD = 3'd1, ST = 3'd2, RMW = 3'd3} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, LD = 3'd1, ST = 3'd2, RMW_RD = 3'd3, RMW_WR = 3'd4} state_t;
`endif

  state_t      state_r, state_s;
  logic        we_r, uns_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r;
`ifndef LSU_ONECYC_RMW_EN
  logic [31:0] rword_r;
`endif
  logic        resp_valid_r, resp_valid_s;
  logic        resp_err_r, resp_err_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        mem_read_s, mem_write_s;
  logic [31:0] addr_s, wd_s, word_addr_s;
  logic        accept_s;

  // Misaligned, illegal size, or last byte beyond the end of memory (33-bit sum avoids wrap).
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] a);
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, a} + {30'd0, nbytes};
    access_err = (size == 2'b11) ||
                 ((size == 2'b01) && a[0]) ||
                 ((size == 2'b10) && (a[1:0] != 2'b00)) ||
                 (end_addr > 33'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_extract = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    case (size)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    store_merge = (word & ~mask) | ((data << {off, 3'b000}) & mask);
  endfunction

  assign accept_s    = req_valid && (state_r == IDLE);
  assign word_addr_s = {addr_r[31:2], 2'b00};

  // State register; reset drops MemRead/MemWrite asynchronously since they decode from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture and read-data capture for the two-cycle read-modify-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
`ifndef LSU_ONECYC_RMW_EN
      rword_r <= 32'd0;
`endif
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        size_r  <= req_size;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
`ifndef LSU_ONECYC_RMW_EN
      if (state_r == RMW_RD) begin
        rword_r <= rd;
      end
`endif
    end
  end

  // Response registers: the pulse lands in the IDLE cycle after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
    end
  end

  // Next state, memory port drive and next response.
  always_comb begin
    state_s      = state_r;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'd0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    addr_s       = 32'd0;
    wd_s         = 32'd0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (access_err(req_size, req_addr)) begin
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
            state_s      = IDLE;
          end else if (!req_we) begin
            state_s = LD;
          end else if (req_size == 2'b10) begin
            state_s = ST;
          end else begin
`ifdef LSU_ONECYC_RMW_EN
            state_s = RMW;
`else
            state_s = RMW_RD;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      LD: begin
        mem_read_s   = 1'b1;
        addr_s       = word_addr_s;
        resp_valid_s = 1'b1;
        resp_rdata_s = load_extract(rd, size_r, addr_r[1:0], uns_r);
        state_s      = IDLE;
      end
      ST: begin
        mem_write_s  = 1'b1;
        addr_s       = word_addr_s;
        wd_s         = wdata_r;
        resp_valid_s = 1'b1;
        state_s      = IDLE;
      end
`ifdef LSU_ONECYC_RMW_EN
      RMW: begin
        mem_read_s   = 1'b1;
        mem_write_s  = 1'b1;
        addr_s       = word_addr_s;
        wd_s         = store_merge(rd, wdata_r, size_r, addr_r[1:0]);
        resp_valid_s = 1'b1;
        state_s      = IDLE;
      end
`else
      RMW_RD: begin
        mem_read_s = 1'b1;
        addr_s     = word_addr_s;
        state_s    = RMW_WR;
      end
      RMW_WR: begin
        mem_write_s  = 1'b1;
        addr_s       = word_addr_s;
        wd_s         = store_merge(rword_r, wdata_r, size_r, addr_r[1:0]);
        resp_valid_s = 1'b1;
        state_s      = IDLE;
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign MemRead    = mem_read_s;
  assign MemWrite   = mem_write_s;
  assign addr       = addr_s;
  assign wd         = wd_s;

endmodule
